enum_seq_gen: RTL

//   Parametrised successor to the constant enum-typed output top: drives a typed-enum

---
 rtl/enum_seq_pkg.sv | 31 +++
 rtl/enum_seq_dwell_cnt.sv | 29 ++
 rtl/enum_seq_gen.sv | 76 +++++++
 3 files changed

// File: rtl/enum_seq_pkg.sv
// Shared types for the enum sequence generator: state codes and the code-stepping helper.
// ENUM_SEQ_GRAY_EN selects Gray-ordered codes (X=1, Y=3, Z=2) instead of binary.
package enum_seq_pkg;

`ifdef ENUM_SEQ_GRAY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        X    = 2'd1,
        Y    = 2'd3,
        Z    = 2'd2
    } seq_state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        X    = 2'd1,
        Y    = 2'd2,
        Z    = 2'd3
    } seq_state_e;
`endif

    // Z wraps to X; the caller decides whether a one-shot run ends in IDLE instead.
    function automatic seq_state_e next_code(input seq_state_e cur);
        case (cur)
            X:       return Y;
            Y:       return Z;
            Z:       return X;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/enum_seq_dwell_cnt.sv
// Dwell counter: counts accepted beats on the current code; last flags the final beat.
module enum_seq_dwell_cnt #(
    parameter int DWELL = 4,
    localparam int CNT_W = $clog2(DWELL + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/enum_seq_gen.sv
// Enum sequence source: steps IDLE -> X -> Y -> Z, holding each code for DWELL accepted beats.
// Code values follow ENUM_SEQ_GRAY_EN (see enum_seq_pkg); timing is identical in both builds.
module enum_seq_gen
    import enum_seq_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    seq_state_e state_q;
    logic       loop_q;
    logic       done_q;
    logic       last;
    logic       accepted;
    logic       cnt_clr;
    logic       cnt_inc;
    logic [1:0] code;

    assign accepted = (state_q != IDLE) && out_ready;
    // Counter restarts on every code change and whenever the sequence is not running.
    assign cnt_clr  = (state_q == IDLE) || stop || (accepted && last);
    assign cnt_inc  = accepted && !last;

    enum_seq_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start && !stop) begin
                    state_q <= X;
                    loop_q  <= loop;
                end
            end else if (stop) begin
                state_q <= IDLE;
            end else if (accepted && last) begin
                if (state_q == Z && !loop_q) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= next_code(state_q);
                end
            end
        end
    end

    assign code      = state_q;
    assign o         = WIDTH'(code);
    assign out_valid = (state_q != IDLE);
    assign busy      = out_valid;
    assign done      = done_q;

endmodule
